// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the RV32I load/store stage.
// Each access takes two cycles: the request is captured in IDLE, then
// executed in ACCESS while clk_stall is held high for one cycle.
// Byte, half and word loads (signed or unsigned) and byte-lane stores are
// supported. A memory-mapped LED register sits at LED_ADDR.
// Misaligned or unmapped accesses raise a one-cycle fault pulse.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
  parameter int unsigned LED_WIDTH   = 8,
  parameter string       INIT_FILE   = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 fault
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t      state;
  logic [31:0] addr_buf;
  logic [31:0] wdata_buf;
  logic [3:0]  sm_buf;
  logic        rd_buf;
  logic        wr_buf;

  logic [31:0] mem [DEPTH_WORDS];

  logic [1:0]       off;
  logic [31:0]      rel;
  logic [IDX_W-1:0] idx;
  logic             is_led;
  logic             in_range;
  logic             sz_byte;
  logic             sz_half;
  logic             misaligned;
  logic             bad;
  logic [3:0]       lanes;
  logic [31:0]      wshift;
  logic [31:0]      mem_word;
  logic [31:0]      shifted;
  logic [31:0]      ext_val;
  logic [31:0]      load_result;
  logic             mem_we;

  // Decode the buffered request: word index, mapping, alignment, lane mask and load value.
  always_comb begin
    off      = addr_buf[1:0];
    rel      = addr_buf - BASE_ADDR;
    idx      = rel[IDX_W+1:2];
    is_led   = (addr_buf == LED_ADDR);
    in_range = (addr_buf >= BASE_ADDR) && ((rel >> 2) < 32'(DEPTH_WORDS));
    // Anything that is not exactly byte or half is handled as a word access.
    sz_byte  = (sm_buf[2:0] == 3'b001);
    sz_half  = (sm_buf[2:0] == 3'b010);
    misaligned = (sz_half && off[0]) || (!sz_byte && !sz_half && (off != 2'd0));
    bad      = (!is_led && !in_range) || misaligned;

    if (sz_byte)      lanes = 4'b0001 << off;
    else if (sz_half) lanes = 4'b0011 << off;
    else              lanes = 4'b1111;

    wshift   = wdata_buf << {off, 3'b000};
    mem_word = mem[idx];
    shifted  = mem_word >> {off, 3'b000};

    if (sz_byte)      ext_val = {{24{sm_buf[3] & shifted[7]}}, shifted[7:0]};
    else if (sz_half) ext_val = {{16{sm_buf[3] & shifted[15]}}, shifted[15:0]};
    else              ext_val = mem_word;

    if (bad)         load_result = '0;
    else if (is_led) load_result = 32'(led);
    else             load_result = ext_val;

    mem_we = (state == S_ACCESS) && wr_buf && !bad && !is_led;
  end

  // Byte-lane array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  // Access FSM with registered stall, fault, LED and load-result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      clk_stall <= 1'b0;
      fault     <= 1'b0;
      led       <= '0;
      read_data <= '0;
      addr_buf  <= '0;
      wdata_buf <= '0;
      sm_buf    <= '0;
      rd_buf    <= 1'b0;
      wr_buf    <= 1'b0;
    end else begin
      fault <= 1'b0;
      case (state)
        S_IDLE: begin
          addr_buf  <= addr;
          wdata_buf <= write_data;
          sm_buf    <= sign_mask;
          rd_buf    <= memread;
          wr_buf    <= memwrite;
          if (memread || memwrite) begin
            state     <= S_ACCESS;
            clk_stall <= 1'b1;
          end else begin
            clk_stall <= 1'b0;
          end
        end
        S_ACCESS: begin
          state     <= S_IDLE;
          clk_stall <= 1'b0;
          fault     <= bad;
          // A simultaneous read and write is a store; read_data is left alone.
          if (wr_buf) begin
            if (!bad && is_led) led <= wdata_buf[LED_WIDTH-1:0];
          end else if (rd_buf) begin
            read_data <= load_result;
          end
        end
        default: begin
          state     <= S_IDLE;
          clk_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised self-checking bench for data_mem_ctrl against a byte-level
// behavioural model of the data array, LED register and load result.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] LEDA  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic [7:0]  led;
  logic        clk_stall;
  logic        fault;

  data_mem_ctrl #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .LED_ADDR   (LEDA),
    .LED_WIDTH  (8),
    .INIT_FILE  ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr      (addr),
    .write_data(write_data),
    .memwrite  (memwrite),
    .memread   (memread),
    .sign_mask (sign_mask),
    .read_data (read_data),
    .led       (led),
    .clk_stall (clk_stall),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] mdl [DEPTH];
  logic [7:0]  led_m;
  logic [31:0] rd_m;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: acts on byte addresses with plain arithmetic.
  task automatic model_op(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] sm, output bit flt);
    int unsigned size;
    int unsigned widx;
    int unsigned boff;
    bit          led_hit;
    bit          mapped;
    logic [63:0] v;
    logic [63:0] msk;
    size    = (sm[2:0] == 3'd1) ? 1 : (sm[2:0] == 3'd2) ? 2 : 4;
    led_hit = (a == LEDA);
    mapped  = led_hit || ((a >= BASE) && ((a - BASE) / 4 < DEPTH));
    flt     = !mapped || ((a % size) != 0);
    widx    = mapped && !led_hit ? int'((a - BASE) / 4) : 0;
    boff    = a % 4;
    if (wr) begin
      if (!flt) begin
        if (led_hit) led_m = wd[7:0];
        else for (int unsigned i = 0; i < size; i++)
          mdl[widx][8*(boff+i) +: 8] = wd[8*i +: 8];
      end
    end else if (rd) begin
      if (flt)          rd_m = '0;
      else if (led_hit) rd_m = {24'h0, led_m};
      else begin
        msk = (64'd1 << (8*size)) - 64'd1;
        v   = ({32'h0, mdl[widx]} >> (8*boff)) & msk;
        if (sm[3] && size < 4 && v[8*size-1]) v = v | ~msk;
        rd_m = v[31:0];
      end
    end
  endtask

  // One access: request sampled on the next edge, committed on the one after.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] sm);
    bit ef;
    memread = rd; memwrite = wr; addr = a; write_data = wd; sign_mask = sm;
    model_op(rd, wr, a, wd, sm, ef);
    @(posedge clk); #1;
    check_eq("stall_during", {31'h0, clk_stall}, 32'd1);
    check_eq("fault_during", {31'h0, fault}, 32'd0);
    @(posedge clk); #1;
    check_eq("stall_after", {31'h0, clk_stall}, 32'd0);
    check_eq("fault", {31'h0, fault}, {31'h0, ef});
    check_eq("read_data", read_data, rd_m);
    check_eq("led", {24'h0, led}, {24'h0, led_m});
  endtask

  task automatic idle_cycle();
    memread = 1'b0; memwrite = 1'b0;
    addr = $urandom; write_data = $urandom; sign_mask = 4'($urandom);
    @(posedge clk); #1;
    check_eq("idle_stall", {31'h0, clk_stall}, 32'd0);
    check_eq("idle_fault", {31'h0, fault}, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    int unsigned sel;
    rst_n = 1'b0; memread = 1'b0; memwrite = 1'b0;
    addr = '0; write_data = '0; sign_mask = '0;
    led_m = '0; rd_m = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_stall", {31'h0, clk_stall}, 32'd0);
    check_eq("rst_fault", {31'h0, fault}, 32'd0);
    check_eq("rst_led", {24'h0, led}, 32'd0);
    check_eq("rst_rdata", read_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill the array so every model word is known.
    for (int unsigned i = 1; i < DEPTH; i++) access(1'b0, 1'b1, BASE + 4*i, $urandom, 4'b0100);
    access(1'b0, 1'b1, BASE, 32'h80FF_7F01, 4'b0100);

    access(1'b1, 1'b0, BASE,     '0, 4'b0100); check_eq("t1_lw",  read_data, 32'h80FF_7F01);
    access(1'b1, 1'b0, BASE + 2, '0, 4'b1001); check_eq("t2_lb",  read_data, 32'hFFFF_FFFF);
    access(1'b1, 1'b0, BASE + 3, '0, 4'b0001); check_eq("t2_lbu", read_data, 32'h0000_0080);
    access(1'b1, 1'b0, BASE + 2, '0, 4'b1010); check_eq("t2_lh",  read_data, 32'hFFFF_80FF);
    access(1'b0, 1'b1, BASE + 1, 32'hAA, 4'b0001);
    access(1'b1, 1'b0, BASE,     '0, 4'b0100); check_eq("t3_sb",  read_data, 32'h80FF_AA01);
    access(1'b0, 1'b1, BASE + 2, 32'h1234, 4'b0010);
    access(1'b1, 1'b0, BASE,     '0, 4'b0100); check_eq("t3_sh",  read_data, 32'h1234_AA01);
    access(1'b0, 1'b1, LEDA, 32'h5A, 4'b0100); check_eq("t4_led", {24'h0, led}, 32'h5A);
    access(1'b1, 1'b0, LEDA, '0, 4'b0100);     check_eq("t4_lw_led", read_data, 32'h5A);

    // Reset while a store is in flight: store dropped, stall falls at once.
    memread = 1'b0; memwrite = 1'b1; addr = BASE + 12; write_data = 32'hDEAD_BEEF; sign_mask = 4'b0100;
    @(posedge clk); #1;
    check_eq("t4_pre_stall", {31'h0, clk_stall}, 32'd1);
    rst_n = 1'b0; #1;
    check_eq("t4_rst_stall", {31'h0, clk_stall}, 32'd0);
    check_eq("t4_rst_led", {24'h0, led}, 32'd0);
    led_m = '0; rd_m = '0;
    memwrite = 1'b0;
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, 1'b0, BASE + 12, '0, 4'b0100);

    access(1'b1, 1'b0, BASE + 1, '0, 4'b1010);
    check_eq("t5_mis_rd", read_data, 32'd0);
    access(1'b0, 1'b1, BASE + 4*DEPTH, 32'h0BAD_0BAD, 4'b0100);
    access(1'b1, 1'b0, BASE, '0, 4'b0100); check_eq("t5_w0", read_data, 32'h1234_AA01);

    // Back-to-back with requests held: lw, sw, lw.
    access(1'b1, 1'b0, BASE + 8, '0, 4'b0100);
    access(1'b0, 1'b1, BASE + 8, 32'hCAFE_F00D, 4'b0100);
    access(1'b1, 1'b0, BASE + 8, '0, 4'b0100); check_eq("t6_lw", read_data, 32'hCAFE_F00D);

    for (int unsigned n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5)      a = BASE + 4*$urandom_range(0, DEPTH-1) + $urandom_range(0, 3);
      else if (sel == 6) a = LEDA;
      else if (sel == 7) a = LEDA + $urandom_range(1, 3);
      else if (sel == 8) a = BASE - $urandom_range(1, 8);
      else               a = BASE + 4*DEPTH + $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       idle_cycle();
        1:       access(1'b1, 1'b0, a, $urandom, 4'($urandom));
        2:       access(1'b0, 1'b1, a, $urandom, 4'($urandom));
        default: access(1'b1, 1'b1, a, $urandom, 4'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
